l1_dcache_param: RTL and testbench

Parametrised N-way set-associative, write-back, write-allocate L1 data cache with multi-word lines, byte-enabled stores, true-LRU replacement, and valid/ready handshakes on both the CPU side and the memory side. It sits between the core load/store unit and the L2/memory port. It replaces the fixed 4 KB, 2-way, one-word-per-line cache.

---
 rtl/l1_dcache_param.sv | 250 +++++++++++++++++++++++++
 tb/tb_l1_dcache_param.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/l1_dcache_param.sv
// l1_dcache_param: N-way set-associative, write-back/write-allocate L1 data cache
// with multi-word lines, byte-enabled stores, true-LRU and valid/ready handshakes.
//
// state     | meaning
// IDLE      | ready for a CPU request
// LOOKUP    | parallel tag compare; hit updates LRU/data, miss picks a victim
// WRITEBACK | stream dirty victim line to memory, one beat per handshake
// FILL_REQ  | issue line-fill request at the line base address
// FILL_WAIT | write returning beats into the victim way, then retry lookup
// RESPOND   | raise resp_valid for one cycle
module l1_dcache_param #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int NUM_SETS       = 64,
    parameter int NUM_WAYS       = 2,
    parameter int CNT_W          = 32   // counter width, at most 32; saturates at all-ones
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count
);
    localparam int BE_W  = DATA_W / 8;
    localparam int BB    = $clog2(BE_W);
    localparam int WB    = $clog2(WORDS_PER_LINE);
    localparam int IB    = $clog2(NUM_SETS);
    localparam int TB    = ADDR_W - IB - WB - BB;
    localparam int WB_W  = (WB > 0) ? WB : 1;
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int AGE_W = WAY_W;
    localparam logic [WB_W-1:0] LAST_BEAT = WB_W'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {
        IDLE, LOOKUP, WRITEBACK, FILL_REQ, FILL_WAIT, RESPOND
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] req_addr_q;
    logic              req_we_q;
    logic [DATA_W-1:0] req_wdata_q;
    logic [BE_W-1:0]   req_be_q;
    logic [TB-1:0]     req_tag;
    logic [IB-1:0]     req_idx;
    logic [WB_W-1:0]   req_word;
    logic [WAY_W-1:0]  victim_q, hit_way, victim_way;
    logic [WB_W-1:0]   beat_q;
    logic              hit_any, victim_found, victim_dirty, last_beat;
    logic              unused_lsb;
    logic [DATA_W-1:0] rdata_q;
    logic [CNT_W-1:0]  hit_cnt, miss_cnt;

    logic [DATA_W-1:0] data_mem [NUM_WAYS][NUM_SETS][WORDS_PER_LINE];
    logic [TB-1:0]     tag_mem  [NUM_WAYS][NUM_SETS];
    logic              valid_q  [NUM_WAYS][NUM_SETS];
    logic              dirty_q  [NUM_WAYS][NUM_SETS];
    logic [AGE_W-1:0]  age_q    [NUM_SETS][NUM_WAYS];

    function automatic logic [ADDR_W-1:0] line_addr(input logic [TB-1:0] t,
                                                    input logic [IB-1:0] i,
                                                    input logic [WB_W-1:0] w);
        return (ADDR_W'(t) << (IB + WB + BB)) | (ADDR_W'(i) << (WB + BB)) | (ADDR_W'(w) << BB);
    endfunction

    assign req_tag    = req_addr_q[ADDR_W-1 -: TB];
    assign req_idx    = req_addr_q[BB+WB +: IB];
    assign unused_lsb = ^(req_addr_q & ADDR_W'((1 << BB) - 1));
    assign last_beat  = (beat_q == LAST_BEAT);
    assign req_ready  = (state_q == IDLE) && !reset;
    assign hit_count  = 32'(hit_cnt);
    assign miss_count = 32'(miss_cnt);

    generate
        if (WB > 0) begin : g_word
            assign req_word = req_addr_q[BB +: WB];
        end else begin : g_no_word
            assign req_word = '0;
        end
    endgenerate

    // Victim: lowest-numbered invalid way, otherwise the oldest (age NUM_WAYS-1).
    always_comb begin
        hit_any      = 1'b0;
        hit_way      = '0;
        victim_way   = '0;
        victim_found = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[w][req_idx] && (tag_mem[w][req_idx] == req_tag)) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!victim_found && !valid_q[w][req_idx]) begin
                victim_way   = WAY_W'(w);
                victim_found = 1'b1;
            end
        end
        if (!victim_found) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (age_q[req_idx][w] == AGE_W'(NUM_WAYS - 1)) begin
                    victim_way = WAY_W'(w);
                end
            end
        end
        victim_dirty = valid_q[victim_way][req_idx] && dirty_q[victim_way][req_idx];
    end

    always_comb begin
        state_d       = state_q;
        mem_req_valid = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        case (state_q)
            IDLE: begin
                if (req_valid) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (hit_any)           state_d = RESPOND;
                else if (victim_dirty) state_d = WRITEBACK;
                else                   state_d = FILL_REQ;
            end
            WRITEBACK: begin
                mem_req_valid = 1'b1;
                mem_we        = 1'b1;
                mem_addr      = line_addr(tag_mem[victim_q][req_idx], req_idx, beat_q);
                mem_wdata     = data_mem[victim_q][req_idx][beat_q];
                if (mem_req_ready && last_beat) state_d = FILL_REQ;
            end
            FILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_addr      = line_addr(req_tag, req_idx, '0);
                if (mem_req_ready) state_d = FILL_WAIT;
            end
            FILL_WAIT: begin
                if (mem_rvalid && last_beat) state_d = LOOKUP;
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_addr_q  <= '0;
            req_we_q    <= 1'b0;
            req_wdata_q <= '0;
            req_be_q    <= '0;
            victim_q    <= '0;
            beat_q      <= '0;
            rdata_q     <= '0;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            hit_cnt     <= '0;
            miss_cnt    <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                    age_q[s][w]   <= AGE_W'(w);
                end
            end
        end else begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        req_addr_q  <= req_addr;
                        req_we_q    <= req_we;
                        req_wdata_q <= req_wdata;
                        req_be_q    <= req_be;
                    end
                end
                LOOKUP: begin
                    beat_q <= '0;
                    if (hit_any) begin
                        rdata_q <= data_mem[hit_way][req_idx][req_word];
                        if (req_we_q) dirty_q[hit_way][req_idx] <= 1'b1;
                        for (int w = 0; w < NUM_WAYS; w++) begin
                            if (WAY_W'(w) == hit_way)
                                age_q[req_idx][w] <= '0;
                            else if (age_q[req_idx][w] < age_q[req_idx][hit_way])
                                age_q[req_idx][w] <= age_q[req_idx][w] + AGE_W'(1);
                        end
                        if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
                    end else begin
                        victim_q <= victim_way;
                        if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
                    end
                end
                WRITEBACK: begin
                    if (mem_req_ready) begin
                        beat_q <= last_beat ? '0 : beat_q + WB_W'(1);
                        if (last_beat) dirty_q[victim_q][req_idx] <= 1'b0;
                    end
                end
                FILL_WAIT: begin
                    if (mem_rvalid) begin
                        beat_q <= last_beat ? '0 : beat_q + WB_W'(1);
                        if (last_beat) begin
                            valid_q[victim_q][req_idx] <= 1'b1;
                            dirty_q[victim_q][req_idx] <= 1'b0;
                        end
                    end
                end
                RESPOND: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= req_we_q ? '0 : rdata_q;
                end
                default: ;
            endcase
        end
    end

    // Line storage is not reset; valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (state_q == LOOKUP && hit_any && req_we_q) begin
            for (int b = 0; b < BE_W; b++) begin
                if (req_be_q[b])
                    data_mem[hit_way][req_idx][req_word][8*b +: 8] <= req_wdata_q[8*b +: 8];
            end
        end
        if (state_q == FILL_WAIT && mem_rvalid) begin
            data_mem[victim_q][req_idx][beat_q] <= mem_rdata;
            if (last_beat) tag_mem[victim_q][req_idx] <= req_tag;
        end
    end

endmodule

// File: tb/tb_l1_dcache_param.sv
// Directed bench for l1_dcache_param: 2-way, 4 sets, 4-word lines, 4-bit counters
// so saturation is reachable; a cycle-stepped memory responder lives in access().
module tb_l1_dcache_param;
    logic        clk;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        mem_req_valid, mem_req_ready, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] hit_count, miss_count;

    int          checks, errors;
    int          nwb, nfill, wb_before_fill, lat;
    logic [31:0] wb_addr [8];
    logic [31:0] wb_data [8];
    logic [31:0] fill_addr, rd;

    l1_dcache_param #(
        .ADDR_W(32), .DATA_W(32), .WORDS_PER_LINE(4), .NUM_SETS(4), .NUM_WAYS(2), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One CPU request; serves memory at every negedge. lat counts negedges after the
    // accepting edge up to the one that sees resp_valid. Fill beat k = {4{fbase+k}}.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [7:0] fbase,
                          input int stall_beat, input int abort_beat);
        int          n, fb, stall_left, k;
        logic        done, fill_acc;
        logic [31:0] h_addr, h_data;
        logic [7:0]  bv;
        nwb = 0; nfill = 0; wb_before_fill = -1; lat = -1; rd = 32'hxxxx_xxxx;
        fill_addr = 32'hxxxx_xxxx;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        n = 1; fb = 0; done = 1'b0; fill_acc = 1'b0; stall_left = 5;
        h_addr = '0; h_data = '0;
        while (!done && n < 80) begin
            mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
            if (resp_valid) begin
                rd = resp_rdata; lat = n; done = 1'b1;
            end else if (mem_req_valid && mem_we) begin
                if (nwb == stall_beat && stall_left > 0) begin
                    if (stall_left == 5) begin
                        h_addr = mem_addr; h_data = mem_wdata;
                    end else begin
                        check("wb_stall_addr", mem_addr, h_addr);
                        check("wb_stall_data", mem_wdata, h_data);
                    end
                    stall_left--;
                end else begin
                    if (nwb == stall_beat) begin
                        check("wb_release_addr", mem_addr, h_addr);
                        check("wb_release_data", mem_wdata, h_data);
                    end
                    if (nwb < 8) begin
                        wb_addr[nwb] = mem_addr; wb_data[nwb] = mem_wdata;
                    end
                    nwb++;
                    mem_req_ready = 1'b1;
                end
            end else if (mem_req_valid && !mem_we) begin
                fill_addr = mem_addr; nfill++; wb_before_fill = nwb;
                mem_req_ready = 1'b1; fill_acc = 1'b1;
            end else if (fill_acc && fb < 4) begin
                if (fb == abort_beat) begin
                    reset = 1'b1; done = 1'b1;
                end else begin
                    bv = fbase + 8'(fb);
                    mem_rvalid = 1'b1; mem_rdata = {4{bv}}; fb++;
                end
            end
            if (!done) begin
                @(negedge clk);
                n++;
            end
        end
        mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        check("resp_seen", 32'(done), 32'd1);
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_be = '0; mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_hit", hit_count, 32'd0);
        check("rst_miss", miss_count, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(req_ready), 32'd1);

        // cold load, clean miss into set 0 way 0
        access(1'b0, 32'h40, '0, '0, 8'hA0, -1, -1);
        check("cold_rdata", rd, 32'hA0A0A0A0);
        check("cold_lat", lat, 32'd9);
        check("cold_nwb", nwb, 32'd0);
        check("cold_nfill", nfill, 32'd1);
        check("cold_fill_addr", fill_addr, 32'h40);
        check("cold_miss", miss_count, 32'd1);
        check("cold_hit", hit_count, 32'd1);

        // partial store then load back
        access(1'b1, 32'h44, 32'hDEADBEEF, 4'b0011, 8'h00, -1, -1);
        check("st_lat", lat, 32'd3);
        check("st_rdata", rd, 32'd0);
        check("st_nfill", nfill, 32'd0);
        access(1'b0, 32'h44, '0, '0, 8'h00, -1, -1);
        check("ld_merge_rdata", rd, 32'hA1A1BEEF);
        check("ld_merge_lat", lat, 32'd3);
        check("ld_merge_hit", hit_count, 32'd3);

        // tag 2 into way 1, dirty it, touch tag 1
        access(1'b0, 32'h80, '0, '0, 8'hB0, -1, -1);
        check("t2_rdata", rd, 32'hB0B0B0B0);
        check("t2_lat", lat, 32'd9);
        check("t2_nwb", nwb, 32'd0);
        check("t2_fill_addr", fill_addr, 32'h80);
        access(1'b1, 32'h88, 32'h12345678, 4'b1111, 8'h00, -1, -1);
        check("t2_st_lat", lat, 32'd3);
        access(1'b0, 32'h40, '0, '0, 8'h00, -1, -1);
        check("t1_touch_rdata", rd, 32'hA0A0A0A0);
        check("t1_touch_lat", lat, 32'd3);
        check("t1_touch_hit", hit_count, 32'd6);

        // tag 3 evicts dirty tag 2, with a 5-cycle stall on writeback beat 1
        access(1'b0, 32'hC0, '0, '0, 8'hC0, 1, -1);
        check("evict_nwb", nwb, 32'd4);
        check("evict_wb_before_fill", wb_before_fill, 32'd4);
        for (int i = 0; i < 4; i++) check("evict_wb_addr", wb_addr[i], 32'h80 + 32'(4 * i));
        check("evict_wb_d0", wb_data[0], 32'hB0B0B0B0);
        check("evict_wb_d1", wb_data[1], 32'hB1B1B1B1);
        check("evict_wb_d2", wb_data[2], 32'h12345678);
        check("evict_wb_d3", wb_data[3], 32'hB3B3B3B3);
        check("evict_fill_addr", fill_addr, 32'hC0);
        check("evict_lat", lat, 32'd18);
        check("evict_rdata", rd, 32'hC0C0C0C0);
        check("evict_miss", miss_count, 32'd3);
        check("evict_hit", hit_count, 32'd7);

        // tag 2 again: evicts dirty tag 1 carrying the merged store
        access(1'b0, 32'h80, '0, '0, 8'hB0, -1, -1);
        check("re_nwb", nwb, 32'd4);
        check("re_wb_a0", wb_addr[0], 32'h40);
        check("re_wb_a3", wb_addr[3], 32'h4C);
        check("re_wb_d0", wb_data[0], 32'hA0A0A0A0);
        check("re_wb_d1", wb_data[1], 32'hA1A1BEEF);
        check("re_lat", lat, 32'd13);
        check("re_rdata", rd, 32'hB0B0B0B0);
        check("re_miss", miss_count, 32'd4);
        access(1'b0, 32'hCC, '0, '0, 8'h00, -1, -1);
        check("t3_w3_rdata", rd, 32'hC3C3C3C3);
        check("t3_w3_lat", lat, 32'd3);
        check("t3_w3_hit", hit_count, 32'd9);

        // reset during fill beat 2
        access(1'b0, 32'hD0, '0, '0, 8'hD0, -1, 2);
        @(negedge clk);
        check("abort_mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        check("abort_miss_cleared", miss_count, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_resp", 32'(resp_valid), 32'd0);
        end
        access(1'b0, 32'hD0, '0, '0, 8'hD0, -1, -1);
        check("post_abort_lat", lat, 32'd9);
        check("post_abort_rdata", rd, 32'hD0D0D0D0);
        check("post_abort_miss", miss_count, 32'd1);
        access(1'b0, 32'hC0, '0, '0, 8'hC0, -1, -1);
        check("invalidated_lat", lat, 32'd9);
        check("invalidated_miss", miss_count, 32'd2);
        check("invalidated_hit", hit_count, 32'd2);

        // hit counter saturates at 15 with the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            access(1'b0, 32'hD4, '0, '0, 8'h00, -1, -1);
            check("sat_rdata", rd, 32'hD1D1D1D1);
            check("sat_lat", lat, 32'd3);
        end
        check("sat_hit", hit_count, 32'd15);
        check("sat_miss", miss_count, 32'd2);
        access(1'b0, 32'h110, '0, '0, 8'hE0, -1, -1);
        check("sat_miss_rdata", rd, 32'hE0E0E0E0);
        check("sat_miss_lat", lat, 32'd9);
        check("sat_hit_hold", hit_count, 32'd15);
        check("sat_miss_cnt", miss_count, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
